// File: rtl/bfm_ahbl_slave_mem_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane merge helper
// for the AHB-Lite slave memory model.
package bfm_ahbl_slave_mem_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANES   = DATA_W / 8;
  localparam int unsigned WCNT_W  = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_e;

  // Overlay the enabled byte lanes of data onto base.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] base,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [LANES-1:0]  lanes);
    logic [DATA_W-1:0] w;
    w = base;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lanes[i]) w[8*i +: 8] = data[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/bfm_ahbl_lane_dec.sv
// Decodes transfer size and low address bits into little-endian byte-lane
// enables plus an alignment-violation flag.
module bfm_ahbl_lane_dec
  import bfm_ahbl_slave_mem_pkg::*;
(
  input  logic [2:0]       size,
  input  logic [1:0]       addr_lo,
  output logic [LANES-1:0] lanes_c,
  output logic             misalign_c
);

  always_comb begin
    lanes_c    = '0;
    misalign_c = 1'b0;
    case (size)
      HSIZE_BYTE: lanes_c = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        lanes_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign_c = addr_lo[0];
      end
      HSIZE_WORD: begin
        lanes_c    = 4'b1111;
        misalign_c = |addr_lo;
      end
      default: lanes_c = '0;
    endcase
  end

endmodule

// File: rtl/bfm_ahbl_slave_mem.sv
// AHB-Lite slave memory model: 2^AWIDTH words, configurable wait states,
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module bfm_ahbl_slave_mem
  import bfm_ahbl_slave_mem_pkg::*;
#(
  parameter int unsigned AWIDTH      = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic              HMASTLOCK,
  input  logic [31:0]       HWDATA,
  input  logic              HREADYIN,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int unsigned WORDS = 2 ** AWIDTH;

  state_e                state, state_nx;
  logic [WCNT_W-1:0]     cnt, cnt_nx;

  logic [AWIDTH-1:0]     a_waddr;
  logic                  a_write;
  logic [LANES-1:0]      a_lanes;
  logic                  a_valid;

  logic [DATA_W-1:0]     mem [WORDS];

  logic [LANES-1:0]      lanes_c;
  logic                  misalign_c;
  logic [AWIDTH-1:0]     haddr_word_c;
  logic                  accept_c;
  logic                  err_c;
  logic                  wr_en_c;
  logic [DATA_W-1:0]     rd_new_c;

  logic                  ready_nx;
  hresp_e                resp_nx;
  logic [DATA_W-1:0]     rdata_nx;

  logic                  unused_c;
  assign unused_c = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

  bfm_ahbl_lane_dec u_lane_dec (
    .size       (HSIZE),
    .addr_lo    (HADDR[1:0]),
    .lanes_c    (lanes_c),
    .misalign_c (misalign_c)
  );

  // Address-phase qualification; only states that drive HREADYOUT high take a new phase.
  assign haddr_word_c = HADDR[AWIDTH+1:2];
  assign accept_c     = HSEL && HREADYIN && HTRANS[1] &&
                        ((state == ST_IDLE) || (state == ST_ERR2));
  assign err_c        = (|(HADDR >> (AWIDTH + 2))) || (HSIZE > HSIZE_WORD) || misalign_c;
  assign wr_en_c      = a_valid && a_write && HREADYOUT;

  // Read of the newly addressed word, bypassing a write that commits on the same edge.
  always_comb begin
    rd_new_c = mem[haddr_word_c];
    if (wr_en_c && (a_waddr == haddr_word_c)) begin
      rd_new_c = merge_lanes(mem[haddr_word_c], HWDATA, a_lanes);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE, ST_ERR2: begin
        state_nx = ST_IDLE;
        if (accept_c) begin
          if (err_c) begin
            state_nx = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_nx = ST_WAIT;
            cnt_nx   = WCNT_W'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= WCNT_W'(1)) state_nx = ST_IDLE;
      end
      ST_ERR1: state_nx = ST_ERR2;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_nx = (state_nx == ST_IDLE) || (state_nx == ST_ERR2);
    resp_nx  = ((state_nx == ST_ERR1) || (state_nx == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    rdata_nx = '0;
    if (accept_c && !err_c && !HWRITE && (WAIT_STATES == 0)) begin
      rdata_nx = rd_new_c;
    end else if ((state == ST_WAIT) && (state_nx == ST_IDLE) && a_valid && !a_write) begin
      rdata_nx = mem[a_waddr];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
    end else begin
      HREADYOUT <= ready_nx;
      HRESP     <= resp_nx;
      HRDATA    <= rdata_nx;
    end
  end

  // Pending data-phase control; cleared once the data phase completes with no follow-on.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      a_waddr <= '0;
      a_write <= 1'b0;
      a_lanes <= '0;
      a_valid <= 1'b0;
    end else if (accept_c) begin
      a_waddr <= haddr_word_c;
      a_write <= HWRITE;
      a_lanes <= lanes_c;
      a_valid <= !err_c;
    end else if (HREADYOUT) begin
      a_valid <= 1'b0;
    end
  end

  // Storage is never reset so contents survive a bus reset.
  always_ff @(posedge HCLK) begin
    if (wr_en_c) mem[a_waddr] <= merge_lanes(mem[a_waddr], HWDATA, a_lanes);
  end

endmodule
